// File: rtl/featuremap_pkg.sv
// Shared definitions for the feature-map accumulator:
//   clog2        - ceil(log2(v)), 0 for v <= 1
//   acc_w        - adder-tree width: data width + tree levels + 1 guard bit
//   pix_w        - pixel-counter width for an img x img frame (at least 1)
//   leaky_fn     - arithmetic right shift (rounds toward -inf)
//   sat_fn       - clamp a wide signed value to a w-bit signed range
package featuremap_pkg;

  localparam int MAX_W          = 64;  // working width of the helper functions
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FRAC_BITS  = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int acc_w(input int dw, input int n_ch);
    return dw + clog2(n_ch) + 1;
  endfunction

  function automatic int pix_w(input int img);
    int w;
    w = clog2(img * img);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic signed [MAX_W-1:0] leaky_fn(input logic signed [MAX_W-1:0] v,
                                                       input int sh);
    return v >>> sh;
  endfunction

  function automatic logic signed [MAX_W-1:0] sat_fn(input logic signed [MAX_W-1:0] v,
                                                     input int w);
    logic signed [MAX_W-1:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/fm_adder_tree.sv
// Pipelined signed reduction tree.
//   Clk, Rst  - clock, async active-low reset
//   i_data    - N_CH signed IN_W-bit channels, channel k at [k*IN_W +: IN_W]
//   i_valid   - beat valid
//   o_sum     - exact sum, IN_W+LEVELS+1 bits, LEVELS cycles after the beat
//   o_valid   - i_valid delayed by LEVELS cycles
// Leaves are padded with zeros to 2^LEVELS. Nodes are stored heap-style:
// internal nodes 0..NPAD-2 (registered), leaves NPAD-1..2*NPAD-2 (combinational).
// Every internal node registers once, so each tree level is one pipeline stage.
module fm_adder_tree
  import featuremap_pkg::*;
#(
  parameter int N_CH   = 32,
  parameter int IN_W   = 16,
  parameter int LEVELS = 5
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic [N_CH*IN_W-1:0]        i_data,
  input  logic                        i_valid,
  output logic signed [IN_W+LEVELS:0] o_sum,
  output logic                        o_valid
);

  localparam int OUT_W = IN_W + LEVELS + 1;
  localparam int NPAD  = 1 << LEVELS;

  logic signed [OUT_W-1:0] w_leaf [NPAD];

  always_comb begin
    for (int k = 0; k < NPAD; k++) w_leaf[k] = '0;
    for (int k = 0; k < N_CH; k++) w_leaf[k] = OUT_W'($signed(i_data[k*IN_W +: IN_W]));
  end

  if (LEVELS == 0) begin : g_pass
    assign o_sum   = w_leaf[0];
    assign o_valid = i_valid;
  end else begin : g_tree
    logic signed [OUT_W-1:0] r_node [NPAD-1];
    logic signed [OUT_W-1:0] w_all  [2*NPAD-1];
    logic [LEVELS-1:0]       r_vld;
    logic [LEVELS:0]         w_vld_cat;

    always_comb begin
      for (int i = 0; i < NPAD - 1; i++) w_all[i] = r_node[i];
      for (int i = 0; i < NPAD; i++)     w_all[NPAD-1+i] = w_leaf[i];
    end

    assign w_vld_cat = {r_vld, i_valid};

    always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
        for (int i = 0; i < NPAD - 1; i++) r_node[i] <= '0;
        r_vld <= '0;
      end else begin
        for (int i = 0; i < NPAD - 1; i++) r_node[i] <= w_all[2*i+1] + w_all[2*i+2];
        r_vld <= w_vld_cat[LEVELS-1:0];
      end
    end

    assign o_sum   = w_all[0];
    assign o_valid = w_vld_cat[LEVELS];
  end

endmodule

// File: rtl/layer_featuremap_accum.sv
// Output-feature-map accumulator: sums N_CH channel results, adds a bias,
// applies optional leaky-ReLU and saturates; counts pixels per frame.
//   Clk, Rst   - clock, async active-low reset
//   data_in    - N_CH signed channel results, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   valid_in   - beat valid (gaps allowed)
//   bias_in    - bias value, loaded when bias_we = 1
//   act_en     - 1 = leaky-ReLU, read when the beat is in the activation stage
//   data_out   - saturated result, held while valid_out = 0
//   valid_out  - data_out valid, LEVELS+2 cycles after valid_in
//   frame_done - pulse with the last pixel of each IMG_SIZE x IMG_SIZE frame
//   pix_cnt    - pixels already emitted in the current frame
module layer_featuremap_accum
  import featuremap_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int N_CH        = 32,
  parameter int IMG_SIZE    = 104,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [N_CH*DATA_WIDTH-1:0]   data_in,
  input  logic                         valid_in,
  input  logic [DATA_WIDTH-1:0]        bias_in,
  input  logic                         bias_we,
  input  logic                         act_en,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         valid_out,
  output logic                         frame_done,
  output logic [pix_w(IMG_SIZE)-1:0]   pix_cnt
);

  localparam int LEVELS = clog2(N_CH);
  localparam int ACC_W  = acc_w(DATA_WIDTH, N_CH);
  localparam int PIX_W  = pix_w(IMG_SIZE);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(IMG_SIZE * IMG_SIZE - 1);

  // Data, bias and output share one fixed-point format, so FRAC_BITS only
  // has to describe a legal format; no alignment shift is needed anywhere.
  if (FRAC_BITS < 0 || FRAC_BITS >= DATA_WIDTH) begin : g_bad_fmt
    $error("FRAC_BITS must lie in [0, DATA_WIDTH)");
  end

  logic signed [ACC_W-1:0] w_tree_sum;
  logic                    w_tree_vld;

  fm_adder_tree #(
    .N_CH  (N_CH),
    .IN_W  (DATA_WIDTH),
    .LEVELS(LEVELS)
  ) u_tree (
    .Clk    (Clk),
    .Rst    (Rst),
    .i_data (data_in),
    .i_valid(valid_in),
    .o_sum  (w_tree_sum),
    .o_valid(w_tree_vld)
  );

  // Bias stage. The bias register and the bias-stage sum update on the same
  // edge, so a beat entering together with bias_we still sees the old bias.
  // ACC_W leaves room for the bias: |tree| <= 2^(DW+LEVELS-1), |bias| <= 2^(DW-1).
  logic signed [DATA_WIDTH-1:0] r_bias;
  logic signed [ACC_W-1:0]      r_bias_sum;
  logic                         r_bias_vld;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_bias     <= '0;
      r_bias_sum <= '0;
      r_bias_vld <= 1'b0;
    end else begin
      if (bias_we) r_bias <= bias_in;
      r_bias_sum <= w_tree_sum + ACC_W'(r_bias);
      r_bias_vld <= w_tree_vld;
    end
  end

  // Activation + saturation.
  logic signed [MAX_W-1:0]      w_wide, w_act;
  logic signed [DATA_WIDTH-1:0] w_sat;

  always_comb begin
    w_wide = MAX_W'(r_bias_sum);
    w_act  = (act_en && r_bias_sum[ACC_W-1]) ? leaky_fn(w_wide, LEAKY_SHIFT) : w_wide;
    w_sat  = DATA_WIDTH'(sat_fn(w_act, DATA_WIDTH));
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      if (r_bias_vld) data_out <= w_sat;
      valid_out <= r_bias_vld;
    end
  end

  // Pixel counter advances on the edge that retires each valid output, so it
  // reads as "pixels before this one" while valid_out is high.
  logic [PIX_W-1:0] r_pix;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)           r_pix <= '0;
    else if (valid_out) r_pix <= (r_pix == LAST_PIX) ? '0 : r_pix + PIX_W'(1);
  end

  assign pix_cnt    = r_pix;
  assign frame_done = valid_out && (r_pix == LAST_PIX);

endmodule

// File: tb/tb_layer_featuremap_accum.sv
module tb_layer_featuremap_accum;

  localparam int DW  = 16;
  localparam int NCH = 4;
  localparam int LAT = 4;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  logic [NCH*DW-1:0] data_in  = '0;
  logic              valid_in = 1'b0;
  logic [DW-1:0]     bias_in  = '0;
  logic              bias_we  = 1'b0;
  logic              act_en   = 1'b0;
  logic [DW-1:0]     data_out;
  logic              valid_out, frame_done;
  logic [1:0]        pix_cnt;

  layer_featuremap_accum #(
    .DATA_WIDTH(16), .FRAC_BITS(8), .N_CH(NCH), .IMG_SIZE(2), .LEAKY_SHIFT(3)
  ) u_dut (
    .Clk(Clk), .Rst(Rst), .data_in(data_in), .valid_in(valid_in),
    .bias_in(bias_in), .bias_we(bias_we), .act_en(act_en),
    .data_out(data_out), .valid_out(valid_out), .frame_done(frame_done),
    .pix_cnt(pix_cnt)
  );

  // configuration sweep instances: N_CH = 1, 3, 32
  logic [32*DW-1:0] sw_data  = '0;
  logic             sw_valid = 1'b0;
  logic [DW-1:0]    sw_bias  = '0;
  logic             sw_bwe   = 1'b0;
  logic             sw_act   = 1'b0;
  logic [DW-1:0]    sw_out [3];
  logic             sw_vld [3];
  logic             sw_fd  [3];
  logic [1:0]       sw_pix [3];

  function automatic int swn(input int g);
    return (g == 0) ? 1 : (g == 1) ? 3 : 32;
  endfunction

  function automatic int swlat(input int g);
    return (g == 0) ? 2 : (g == 1) ? 4 : 7;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int N = (g == 0) ? 1 : (g == 1) ? 3 : 32;
    layer_featuremap_accum #(
      .DATA_WIDTH(16), .FRAC_BITS(8), .N_CH(N), .IMG_SIZE(2), .LEAKY_SHIFT(3)
    ) u_sw (
      .Clk(Clk), .Rst(Rst), .data_in(sw_data[N*DW-1:0]), .valid_in(sw_valid),
      .bias_in(sw_bias), .bias_we(sw_bwe), .act_en(sw_act),
      .data_out(sw_out[g]), .valid_out(sw_vld[g]), .frame_done(sw_fd[g]),
      .pix_cnt(sw_pix[g])
    );
  end

  typedef struct {
    logic [15:0] d;
    logic [1:0]  pix;
    logic        fd;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          mcnt  = 0;
  logic [15:0] cur_bias = '0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_px(input logic [32*16-1:0] d, input int n,
                                         input logic [15:0] b, input logic act);
    longint s;
    s = longint'($signed(b));
    for (int k = 0; k < n; k++) s += longint'($signed(d[k*16 +: 16]));
    if (act && s < 0) s = s >>> 3;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  // output monitor / scoreboard pop
  exp_t e;
  always @(negedge Clk) begin
    if (Rst && valid_out) begin
      if (sb.size() == 0) chk("unexp_vld", valid_out, 0);
      else begin
        e = sb.pop_front();
        chk("data", data_out, e.d);
        chk("pix",  pix_cnt,  e.pix);
        chk("fd",   frame_done, e.fd);
        chk("lat",  cyc - e.cyc, LAT);
      end
    end else if (Rst && frame_done) begin
      chk("fd_novld", frame_done, 0);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [NCH*DW-1:0] d, input logic act, input logic [15:0] b);
    data_in  = d;
    valid_in = 1'b1;
    act_en   = act;
    sb.push_back('{ref_px(512'(d), NCH, b, act), mcnt[1:0], (mcnt == 3), cyc});
    mcnt = (mcnt + 1) % 4;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic load_bias(input logic [15:0] b);
    bias_in = b;
    bias_we = 1'b1;
    tick();
    bias_we  = 1'b0;
    cur_bias = b;
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    #1;
    chk("rst_dout", data_out, 0);
    chk("rst_vld",  valid_out, 0);
    chk("rst_fd",   frame_done, 0);
    chk("rst_pix",  pix_cnt, 0);
    sb.delete();
    mcnt     = 0;
    cur_bias = '0;
    tick();
    Rst = 1'b1;
    tick();
  endtask

  int          lat [3];
  logic [15:0] got [3];
  logic [1:0]  gp  [3];
  logic        gfd [3];
  int          c0;

  initial begin
    idle(2);
    do_reset();

    // basic sum
    load_bias(16'h0100);
    send({16'h0080, 16'hFF00, 16'h0200, 16'h0100}, 1'b0, cur_bias);
    idle(6);

    // leaky vs linear on the same beat
    load_bias(16'h0000);
    send({16'h0000, 16'h0000, 16'h0000, 16'hF800}, 1'b1, cur_bias);
    idle(6);
    send({16'h0000, 16'h0000, 16'h0000, 16'hF800}, 1'b0, cur_bias);
    idle(6);

    // saturation at both rails, and leaky on a large negative sum
    load_bias(16'h7FFF);
    send({4{16'h7FFF}}, 1'b0, cur_bias);
    idle(6);
    load_bias(16'h8000);
    send({4{16'h8000}}, 1'b0, cur_bias);
    idle(6);
    send({4{16'h8000}}, 1'b1, cur_bias);
    idle(6);

    // bias timing: bias_we in the cycle beat 3 sits at the tree output
    load_bias(16'h0010);
    for (int k = 0; k < 6; k++) begin
      if (k == 5) begin
        bias_in = 16'h0200;
        bias_we = 1'b1;
      end
      send({4{16'(k * 16 + 1)}}, 1'b0, (k <= 3) ? 16'h0010 : 16'h0200);
      bias_we = 1'b0;
    end
    cur_bias = 16'h0200;
    idle(6);
    chk("drain_a", sb.size(), 0);

    // frames with random gaps (bias cleared by reset)
    do_reset();
    for (int i = 0; i < 9; i++) begin
      send({$urandom, $urandom}, 1'b1, cur_bias);
      idle($urandom_range(0, 3));
    end
    idle(8);
    chk("drain_b", sb.size(), 0);

    // reset with beats in flight
    for (int i = 0; i < 5; i++) send({4{16'h0123}}, 1'b0, cur_bias);
    do_reset();
    idle(8);
    send({16'h0001, 16'h0002, 16'h0003, 16'h0004}, 1'b0, cur_bias);
    idle(6);
    chk("drain_c", sb.size(), 0);

    // configuration sweep
    sw_bias = 16'($urandom);
    sw_bwe  = 1'b1;
    tick();
    sw_bwe  = 1'b0;
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 16; k++) sw_data[k*32 +: 32] = $urandom;
      if (t == 0) sw_data[31:0] = {16'h4000, 16'hF000};
      sw_act   = (t % 2 == 0);
      sw_valid = 1'b1;
      c0 = cyc;
      tick();
      sw_valid = 1'b0;
      for (int g = 0; g < 3; g++) begin
        lat[g] = -1;
        got[g] = '0;
        gp[g]  = '0;
        gfd[g] = 1'b0;
      end
      repeat (10) begin
        @(negedge Clk);
        for (int g = 0; g < 3; g++)
          if (sw_vld[g] && lat[g] < 0) begin
            lat[g] = cyc - c0;
            got[g] = sw_out[g];
            gp[g]  = sw_pix[g];
            gfd[g] = sw_fd[g];
          end
      end
      tick();
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("sw%0d_lat", swn(g)), lat[g], swlat(g));
        chk($sformatf("sw%0d_data", swn(g)), got[g], ref_px(sw_data, swn(g), sw_bias, sw_act));
        chk($sformatf("sw%0d_pix", swn(g)), gp[g], t % 4);
        chk($sformatf("sw%0d_fd", swn(g)), gfd[g], (t % 4 == 3));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
